// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NREQ byte
// producers. It sequences the serializer's tx_cmd/tx_ready handshake. The
// granted byte is held on tx_din for the whole frame, because the serializer
// reads the data bits live while it shifts. All outputs are registered.
module uart_tx_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned ACK_TO = 8
) (
  input  logic              bclk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ack_o,
  input  logic              tx_ready_i,
  output logic              tx_cmd_o,
  output logic [7:0]        tx_din_o,
  output logic              busy_o,
  output logic [IDX_W-1:0]  grant_id_o,
  output logic              frame_done_o,
  output logic              retry_err_o
);

  // The timeout counter only has to hold 0 .. ACK_TO-1.
  localparam int unsigned CntW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StAck   = 2'd2,
    StBusy  = 2'd3
  } state_e;

  state_e           state_q, state_d;

  logic [NREQ-1:0]  req_ack_q, req_ack_d;
  logic             tx_cmd_q, tx_cmd_d;
  logic [7:0]       tx_din_q, tx_din_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic             frame_done_q, frame_done_d;
  logic             retry_err_q, retry_err_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  to_cnt_q, to_cnt_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [7:0]       win_data;
  logic [NREQ-1:0]  valid_rot;
  int unsigned      cand;

  logic             grant_go;
  logic             to_expired;
  logic [IDX_W-1:0] rr_next;

  // Round-robin search: start at rr_ptr, walk upward modulo NREQ, and take
  // the first requester that has valid asserted.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    valid_rot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      valid_rot = req_valid_i >> cand;
      if (!win_found && valid_rot[0]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Byte of the current winner; only sampled on the grant cycle.
  assign win_data = 8'(req_data_i >> (32'(win_idx) * 32'd8));

  // A grant needs an idle serializer and at least one pending request.
  assign grant_go   = (state_q == StIdle) && tx_ready_i && win_found;
  assign to_expired = (to_cnt_q == CntW'(ACK_TO - 1));

  // After a frame, the pointer moves to the requester just past the one served.
  assign rr_next = (grant_id_q == IDX_W'(NREQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

  // State register.
  always_ff @(posedge bclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the issue / ack / busy handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_go) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StAck;
      end
      StAck: begin
        // The serializer drops tx_ready a couple of edges after it sees
        // tx_cmd. If it never drops, the same byte is issued again.
        if (!tx_ready_i) begin
          state_d = StBusy;
        end else if (to_expired) begin
          state_d = StIssue;
        end
      end
      StBusy: begin
        if (tx_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output and datapath next-state. The outputs are registered, so each value
  // is computed here for the state being entered.
  always_comb begin
    req_ack_d    = '0;
    tx_cmd_d     = (state_d == StIssue);
    tx_din_d     = tx_din_q;
    busy_d       = (state_d != StIdle);
    grant_id_d   = grant_id_q;
    frame_done_d = 1'b0;
    retry_err_d  = 1'b0;
    rr_ptr_d     = rr_ptr_q;
    to_cnt_d     = to_cnt_q;
    unique case (state_q)
      StIdle: begin
        // tx_din and grant_id change only here. They hold through the frame.
        if (grant_go) begin
          tx_din_d   = win_data;
          grant_id_d = win_idx;
          req_ack_d  = NREQ'(1) << win_idx;
        end
      end
      StIssue: begin
        to_cnt_d = '0;
      end
      StAck: begin
        if (tx_ready_i) begin
          if (to_expired) begin
            // Re-issue without repeating req_ack: the byte is already owned.
            retry_err_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + CntW'(1);
          end
        end
      end
      StBusy: begin
        if (tx_ready_i) begin
          frame_done_d = 1'b1;
          rr_ptr_d     = rr_next;
        end
      end
      default: begin
        rr_ptr_d = rr_ptr_q;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge bclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ack_q    <= '0;
      tx_cmd_q     <= 1'b0;
      tx_din_q     <= 8'h00;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
      frame_done_q <= 1'b0;
      retry_err_q  <= 1'b0;
      rr_ptr_q     <= '0;
      to_cnt_q     <= '0;
    end else begin
      req_ack_q    <= req_ack_d;
      tx_cmd_q     <= tx_cmd_d;
      tx_din_q     <= tx_din_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      frame_done_q <= frame_done_d;
      retry_err_q  <= retry_err_d;
      rr_ptr_q     <= rr_ptr_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign req_ack_o    = req_ack_q;
  assign tx_cmd_o     = tx_cmd_q;
  assign tx_din_o     = tx_din_q;
  assign busy_o       = busy_q;
  assign grant_id_o   = grant_id_q;
  assign frame_done_o = frame_done_q;
  assign retry_err_o  = retry_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. It pairs the arbiter with a behavioural
// serializer and uses a scoreboard of expected grants and serial frames.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ACK_TO = 8;

  logic              bclk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              tx_ready;
  logic              tx_cmd;
  logic [7:0]        tx_din;
  logic              busy;
  logic [IDX_W-1:0]  grant_id;
  logic              frame_done;
  logic              retry_err;

  uart_tx_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W),
    .ACK_TO(ACK_TO)
  ) dut (
    .bclk_i      (bclk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ack_o   (req_ack),
    .tx_ready_i  (tx_ready),
    .tx_cmd_o    (tx_cmd),
    .tx_din_o    (tx_din),
    .busy_o      (busy),
    .grant_id_o  (grant_id),
    .frame_done_o(frame_done),
    .retry_err_o (retry_err)
  );

  always #5 bclk = ~bclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [7:0]       data;
  } grant_t;

  grant_t     grant_q[$];
  logic [7:0] ser_q[$];

  task automatic expect_grant(input int id, input logic [7:0] d);
    grant_t g;
    g.id   = IDX_W'(id);
    g.data = d;
    grant_q.push_back(g);
    ser_q.push_back(d);
  endtask

  // Behavioural serializer. It drops tx_ready two edges after it samples
  // tx_cmd, reads tx_din bits live while shifting, and checks each frame.
  logic       stuck = 1'b0;
  int         ser_st;
  logic [2:0] dbit;
  logic [9:0] ser_bits;
  int         n_frames_ser = 0;
  logic [7:0] ser_exp;

  always @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b1;
      ser_st   <= 0;
      dbit     <= 3'd0;
    end else if (ser_st == 0) begin
      if (tx_cmd && !stuck) ser_st <= 1;
    end else if (ser_st == 1) begin
      ser_st <= 2;
    end else if (ser_st == 2) begin
      tx_ready <= 1'b0;
      ser_bits <= {1'b0, ser_bits[9:1]};
      dbit     <= 3'd0;
      ser_st   <= 3;
    end else if (ser_st < 11) begin
      ser_bits <= {tx_din[dbit], ser_bits[9:1]};
      dbit     <= dbit + 3'd1;
      ser_st   <= ser_st + 1;
    end else if (ser_st == 11) begin
      ser_bits <= {1'b1, ser_bits[9:1]};
      ser_st   <= 12;
    end else begin
      tx_ready <= 1'b1;
      ser_st   <= 0;
      n_frames_ser++;
      check("serial_expected", 32'(ser_q.size() != 0), 32'd1);
      if (ser_q.size() != 0) begin
        ser_exp = ser_q.pop_front();
        check("serial_frame", 32'(ser_bits), 32'({1'b1, ser_exp, 1'b0}));
      end
    end
  end

  // Monitor: checks grants against the scoreboard, the single-cycle pulses,
  // and that tx_din holds for the whole frame.
  logic       prev_cmd, prev_ack, prev_fd, stable_bad;
  logic [7:0] cur_byte;
  int         n_fd = 0;
  grant_t     g_mon;

  always @(negedge bclk) begin
    if (!rst_n) begin
      prev_cmd   = 1'b0;
      prev_ack   = 1'b0;
      prev_fd    = 1'b0;
      stable_bad = 1'b0;
    end else begin
      if (|req_ack) begin
        check("ack_one_cycle", 32'(prev_ack), 32'd0);
        check("ack_expected", 32'(grant_q.size() != 0), 32'd1);
        if (grant_q.size() != 0) begin
          g_mon = grant_q.pop_front();
          check("ack_onehot", 32'(req_ack), 32'd1 << g_mon.id);
          check("grant_id", 32'(grant_id), 32'(g_mon.id));
          check("tx_din_grant", 32'(tx_din), 32'(g_mon.data));
          cur_byte   = g_mon.data;
          stable_bad = 1'b0;
        end
      end
      if (busy && tx_din !== cur_byte) stable_bad = 1'b1;
      if (tx_cmd) begin
        check("cmd_one_cycle", 32'(prev_cmd), 32'd0);
        check("cmd_ser_idle", 32'(tx_ready), 32'd1);
      end
      if (frame_done) begin
        n_fd++;
        check("fd_one_cycle", 32'(prev_fd), 32'd0);
        check("din_stable", 32'(stable_bad), 32'd0);
      end
      prev_cmd = tx_cmd;
      prev_ack = |req_ack;
      prev_fd  = frame_done;
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    grant_q.delete();
    ser_q.delete();
    repeat (2) @(negedge bclk);
    rst_n = 1'b1;
    @(negedge bclk);
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a);
    a = '0;
    for (int c = 0; c < 300 && a == '0; c++) begin
      @(negedge bclk);
      a = req_ack;
    end
    check("ack_wait", 32'(a != '0), 32'd1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge bclk);
    while ((busy || ser_st != 0) && c < 300) begin
      @(negedge bclk);
      c++;
    end
    check("idle_wait", 32'(busy || ser_st != 0), 32'd0);
    @(negedge bclk);
    check("frame_count", n_fd, n_frames_ser);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(req_ack), 32'd0);
    check({tag, "_cmd"}, 32'(tx_cmd), 32'd0);
    check({tag, "_din"}, 32'(tx_din), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_gid"}, 32'(grant_id), 32'd0);
    check({tag, "_fd"}, 32'(frame_done), 32'd0);
    check({tag, "_rerr"}, 32'(retry_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  logic [NREQ-1:0] a;
  int n_re, n_cmd, n_ack2, last_re, bad_gap, din_bad, busy_drop, c_busy;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge bclk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge bclk);

    // Single request from requester 0.
    req_data[7:0] = 8'hA5;
    expect_grant(0, 8'hA5);
    req_valid = 4'b0001;
    wait_ack(a);
    req_valid = '0;
    wait_idle();

    // Round robin with every requester pending: 0,1,2,3,0.
    do_reset();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    expect_grant(0, 8'h10);
    expect_grant(1, 8'h21);
    expect_grant(2, 8'h32);
    expect_grant(3, 8'h43);
    expect_grant(0, 8'h10);
    req_valid = 4'b1111;
    repeat (5) wait_ack(a);
    req_valid = '0;
    wait_idle();
    check("rr_drained", grant_q.size(), 0);

    // Pointer wrap: after 2 the pointer is 3, so 3 wins over 0.
    do_reset();
    req_data[23:16] = 8'h77;
    expect_grant(2, 8'h77);
    req_valid = 4'b0100;
    wait_ack(a);
    req_valid = '0;
    wait_idle();
    req_data[7:0]   = 8'h0F;
    req_data[31:24] = 8'hF0;
    expect_grant(3, 8'hF0);
    expect_grant(0, 8'h0F);
    req_valid = 4'b1001;
    wait_ack(a);
    req_valid = req_valid & ~a;
    wait_ack(a);
    req_valid = req_valid & ~a;
    wait_idle();

    // Ack timeout: the serializer ignores tx_cmd and tx_ready stays high.
    do_reset();
    stuck           = 1'b1;
    req_data[15:8]  = 8'h5A;
    expect_grant(1, 8'h5A);
    req_valid = 4'b0010;
    wait_ack(a);
    req_valid = '0;
    n_re = 0; n_cmd = 0; n_ack2 = 0; last_re = 0; bad_gap = 0; din_bad = 0; busy_drop = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge bclk);
      if (retry_err) begin
        n_re++;
        if (c - last_re != int'(ACK_TO) + 1) bad_gap++;
        last_re = c;
      end
      if (tx_cmd) n_cmd++;
      if (|req_ack) n_ack2++;
      if (tx_din !== 8'h5A) din_bad++;
      if (!busy) busy_drop++;
    end
    check("retry_count", n_re, 3);
    check("retry_gap", bad_gap, 0);
    check("retry_cmd_count", n_cmd, 3);
    check("retry_no_reack", n_ack2, 0);
    check("retry_din_hold", din_bad, 0);
    check("retry_busy_hold", busy_drop, 0);
    stuck = 1'b0;
    wait_idle();

    // Reset while the serializer is busy with 8'h3C.
    do_reset();
    req_data[7:0] = 8'h3C;
    expect_grant(0, 8'h3C);
    req_valid = 4'b0001;
    wait_ack(a);
    req_valid = '0;
    c_busy = 0;
    while (!(busy && !tx_ready) && c_busy < 50) begin
      @(negedge bclk);
      c_busy++;
    end
    check("reached_busy", 32'(busy && !tx_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    grant_q.delete();
    ser_q.delete();
    #1;
    check_reset_outputs("async_reset");
    @(negedge bclk);
    req_data[23:16] = 8'h96;
    expect_grant(2, 8'h96);
    req_valid = 4'b0100;
    rst_n     = 1'b1;
    wait_ack(a);
    req_valid = '0;
    wait_idle();

    // Data stability: the producer rewrites its byte mid-frame.
    req_data[31:24] = 8'hC3;
    expect_grant(3, 8'hC3);
    req_valid = 4'b1000;
    wait_ack(a);
    req_valid = '0;
    repeat (3) @(negedge bclk);
    req_data = {8'h3C, 8'hFF, 8'hEE, 8'hDD};
    repeat (4) @(negedge bclk);
    check("din_after_change", 32'(tx_din), 32'hC3);
    wait_idle();

    check("grant_q_empty", grant_q.size(), 0);
    check("ser_q_empty", ser_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
